dense_feeder: RTL

DENSE_FEEDER -- requirements
Module: dense_feeder

---
 rtl/dense_feeder_pkg.sv | 15 +
 rtl/feeder_index_counter.sv | 39 +++
 rtl/dense_feeder.sv | 114 +++++++++++
 3 files changed

// File: rtl/dense_feeder_pkg.sv
// Constants shared by the dense layer and its activation feeder:
// default vector geometry and the feeder state encoding.
package dense_feeder_pkg;

    localparam int DEF_IN_COUNT  = 196;
    localparam int DEF_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/feeder_index_counter.sv
// Word index for one vector: clear to 0, step on enable, saturate at IN_COUNT-1.
module feeder_index_counter
    import dense_feeder_pkg::*;
#(
    parameter int IN_COUNT = DEF_IN_COUNT,
    parameter int W        = $clog2(IN_COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] idx_o,
    output logic         last_o
);

    localparam logic [W-1:0] IDX_MAX = W'(IN_COUNT - 1);

    logic [W-1:0] idx_q, idx_d;

    assign last_o = (idx_q == IDX_MAX);
    assign idx_o  = idx_q;

    // Saturating so a stray enable on the last word can never wrap the address.
    always_comb begin
        idx_d = idx_q;
        if (clr_i)
            idx_d = '0;
        else if (en_i && !last_o)
            idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            idx_q <= '0;
        else
            idx_q <= idx_d;
    end

endmodule

// File: rtl/dense_feeder.sv
// Streams one IN_COUNT-word vector from activation RAM to the dense layer, one word per 2 cycles.
// Optional build macro DENSE_FEEDER_RELU_EN clamps negative words to 0 as they are captured.
module dense_feeder
    import dense_feeder_pkg::*;
#(
    parameter int IN_COUNT  = DEF_IN_COUNT,
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        feederBusy,
    output logic                        ram_rd,
    output logic [$clog2(IN_COUNT)-1:0] ram_adr,
    input  logic [DATA_SIZE-1:0]        ram_dataOut,
    input  logic                        denseBusy,
    output logic                        valid,
    output logic [DATA_SIZE-1:0]        dataOut,
    output logic                        done
);

    localparam int AW = $clog2(IN_COUNT);

    feeder_state_t state_q, state_d;
    logic [AW-1:0] idx;
    logic idx_last, idx_clr, idx_en;
    logic first_q;
    logic [DATA_SIZE-1:0] data_q, data_d, rd_word;

    feeder_index_counter #(.IN_COUNT(IN_COUNT), .W(AW)) u_idx (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (idx_clr),
        .en_i   (idx_en),
        .idx_o  (idx),
        .last_o (idx_last)
    );

`ifdef DENSE_FEEDER_RELU_EN
    assign rd_word = ram_dataOut[DATA_SIZE-1] ? '0 : ram_dataOut;
`else
    assign rd_word = ram_dataOut;
`endif

    always_comb begin
        state_d    = state_q;
        idx_clr    = 1'b0;
        idx_en     = 1'b0;
        ram_rd     = 1'b0;
        valid      = 1'b0;
        done       = 1'b0;
        feederBusy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_clr = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                ram_rd     = 1'b1;
                feederBusy = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                valid      = 1'b1;
                feederBusy = 1'b1;
                if (!denseBusy) begin
                    if (idx_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_en  = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ram_adr = ram_rd ? idx : '0;

    // RAM data is only guaranteed in the first SEND cycle: pass it straight
    // through then, and serve the captured copy while the consumer stalls.
    always_comb begin
        data_d  = data_q;
        dataOut = '0;
        if (state_q == ST_SEND) begin
            if (first_q) begin
                data_d  = rd_word;
                dataOut = rd_word;
            end else begin
                dataOut = data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= (state_q == ST_READ);
            data_q  <= data_d;
        end
    end

endmodule
